// File: rtl/wb_completion_if.sv
`default_nettype none
// ============================================================================
// Module : wb_completion_if
// Brief  : Functional-unit result bus and register-file write-port bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface wb_completion_if #(
    parameter int NUM_UNITS = 4
);
    logic [NUM_UNITS-1:0]    fu_wb_valid;
    logic [NUM_UNITS-1:0]    fu_wb_ready;
    logic [NUM_UNITS-1:0]    fu_wb_writereg;
    logic [5*NUM_UNITS-1:0]  fu_wb_regdest;
    logic [32*NUM_UNITS-1:0] fu_wb_data;
    logic [4:0]              wb_reg_writeaddr_a;
    logic [31:0]             wb_reg_writedata_a;
    logic                    wb_reg_enablewrite_a;
    logic [4:0]              wb_reg_writeaddr_b;
    logic [31:0]             wb_reg_writedata_b;
    logic                    wb_reg_enablewrite_b;
    logic                    wb_busy;

    modport master (
        output fu_wb_valid, fu_wb_writereg, fu_wb_regdest, fu_wb_data,
        input  fu_wb_ready,
        input  wb_reg_writeaddr_a, wb_reg_writedata_a, wb_reg_enablewrite_a,
        input  wb_reg_writeaddr_b, wb_reg_writedata_b, wb_reg_enablewrite_b,
        input  wb_busy
    );

    modport slave (
        input  fu_wb_valid, fu_wb_writereg, fu_wb_regdest, fu_wb_data,
        output fu_wb_ready,
        output wb_reg_writeaddr_a, wb_reg_writedata_a, wb_reg_enablewrite_a,
        output wb_reg_writeaddr_b, wb_reg_writedata_b, wb_reg_enablewrite_b,
        output wb_busy
    );
endinterface
`default_nettype wire

// File: rtl/wb_completion.sv
`default_nettype none
// ============================================================================
// Module : wb_completion
// Brief  : Buffers functional-unit results per unit and round-robin arbitrates
//          them onto the two register-file / Scoreboard write ports.
// Rev    : 1.0  initial release
// ============================================================================
module wb_completion #(
    parameter int NUM_UNITS = 4,
    parameter int DEPTH     = 2
) (
    input  wire logic       clock,
    input  wire logic       reset,
    wb_completion_if.slave  bus
);
    localparam int c_UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_EW = 38;

    logic                 r_ready_en;
    logic [c_UW-1:0]      r_rr_ptr;
    logic [c_UW-1:0]      w_rr_next;
    logic [NUM_UNITS-1:0] w_ready;
    logic [NUM_UNITS-1:0] w_push;
    logic [NUM_UNITS-1:0] w_pop;
    logic [NUM_UNITS-1:0] w_head_valid;
    logic [NUM_UNITS-1:0] w_head_wr;
    logic [4:0]           w_head_dest [NUM_UNITS];
    logic [31:0]          w_head_data [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_grant_a;
    logic [NUM_UNITS-1:0] w_grant_b;
    logic                 w_found_a;
    logic                 w_found_b;
    logic [c_UW-1:0]      w_idx_a;
    logic [c_UW-1:0]      w_idx_b;

    logic [4:0]           r_addr_a;
    logic [31:0]          r_data_a;
    logic                 r_en_a;
    logic [4:0]           r_addr_b;
    logic [31:0]          r_data_b;
    logic                 r_en_b;

    generate
        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
            logic [c_EW-1:0] r_mem [DEPTH];
            logic [c_PW-1:0] r_wptr;
            logic [c_PW-1:0] r_rptr;
            logic [c_CW-1:0] r_count;
            logic [c_EW-1:0] w_head;

            assign w_ready[u]      = r_ready_en && (r_count < c_CW'(DEPTH));
            assign w_push[u]       = bus.fu_wb_valid[u] & w_ready[u];
            assign w_head          = r_mem[r_rptr];
            assign w_head_valid[u] = (r_count != '0);
            assign w_head_wr[u]    = w_head[37];
            assign w_head_dest[u]  = w_head[36:32];
            assign w_head_data[u]  = w_head[31:0];

            always_ff @(posedge clock) begin
                if (w_push[u]) begin
                    r_mem[r_wptr] <= {bus.fu_wb_writereg[u],
                                      bus.fu_wb_regdest[5*u +: 5],
                                      bus.fu_wb_data[32*u +: 32]};
                end
            end

            // DEPTH is a power of two, so the pointers wrap naturally.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[u]) r_wptr <= r_wptr + 1'b1;
                    if (w_pop[u])  r_rptr <= r_rptr + 1'b1;
                    case ({w_push[u], w_pop[u]})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // Rotating scan from r_rr_ptr; B skips heads aimed at A's register.
    always_comb begin
        logic [c_UW-1:0] v_sel;
        v_sel     = '0;
        w_grant_a = '0;
        w_grant_b = '0;
        w_found_a = 1'b0;
        w_found_b = 1'b0;
        w_idx_a   = '0;
        w_idx_b   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (c_UW'(i) > (c_UW'(NUM_UNITS - 1) - r_rr_ptr))
                v_sel = r_rr_ptr - c_UW'(NUM_UNITS - i);
            else
                v_sel = r_rr_ptr + c_UW'(i);
            if (w_head_valid[v_sel] && w_head_wr[v_sel]) begin
                if (!w_found_a) begin
                    w_found_a        = 1'b1;
                    w_idx_a          = v_sel;
                    w_grant_a[v_sel] = 1'b1;
                end else if (!w_found_b && (w_head_dest[v_sel] != w_head_dest[w_idx_a])) begin
                    w_found_b        = 1'b1;
                    w_idx_b          = v_sel;
                    w_grant_b[v_sel] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rr_next = r_rr_ptr;
        if (w_found_b)
            w_rr_next = (w_idx_b == c_UW'(NUM_UNITS - 1)) ? '0 : w_idx_b + 1'b1;
        else if (w_found_a)
            w_rr_next = (w_idx_a == c_UW'(NUM_UNITS - 1)) ? '0 : w_idx_a + 1'b1;
    end

    assign w_pop = w_head_valid & (~w_head_wr | w_grant_a | w_grant_b);

    // A grant to r0 still loads the port but never raises its strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
            r_rr_ptr   <= '0;
            r_addr_a   <= '0;
            r_data_a   <= '0;
            r_en_a     <= 1'b0;
            r_addr_b   <= '0;
            r_data_b   <= '0;
            r_en_b     <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            r_rr_ptr   <= w_rr_next;
            r_en_a     <= 1'b0;
            r_en_b     <= 1'b0;
            if (w_found_a) begin
                r_addr_a <= w_head_dest[w_idx_a];
                r_data_a <= w_head_data[w_idx_a];
                r_en_a   <= (w_head_dest[w_idx_a] != 5'd0);
            end
            if (w_found_b) begin
                r_addr_b <= w_head_dest[w_idx_b];
                r_data_b <= w_head_data[w_idx_b];
                r_en_b   <= (w_head_dest[w_idx_b] != 5'd0);
            end
        end
    end

    assign bus.fu_wb_ready          = w_ready;
    assign bus.wb_reg_writeaddr_a   = r_addr_a;
    assign bus.wb_reg_writedata_a   = r_data_a;
    assign bus.wb_reg_enablewrite_a = r_en_a;
    assign bus.wb_reg_writeaddr_b   = r_addr_b;
    assign bus.wb_reg_writedata_b   = r_data_b;
    assign bus.wb_reg_enablewrite_b = r_en_b;
    assign bus.wb_busy              = |w_head_valid;
endmodule
`default_nettype wire

// File: tb/tb_wb_completion.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_completion
// Brief  : Directed bench for wb_completion with a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_completion;
    localparam int NU = 4;
    localparam int DP = 2;

    logic clock = 1'b0;
    logic reset;
    bit   started = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    wb_completion_if #(.NUM_UNITS(NU)) bus ();

    wb_completion #(.NUM_UNITS(NU), .DEPTH(DP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-unit queues of {writereg, regdest, data}
    logic [37:0] mq [NU][$];
    bit          m_ready_en;
    int          m_rr;
    logic [4:0]  e_addr_a, e_addr_b;
    logic [31:0] e_data_a, e_data_b;
    logic        e_en_a, e_en_b;
    logic [31:0] wlog [$];

    always @(posedge clock or negedge reset) begin
        bit rdy [NU];
        int ga, gb, u;
        if (!reset) begin
            for (int k = 0; k < NU; k++) mq[k].delete();
            m_ready_en = 1'b0;
            m_rr = 0;
            e_addr_a = '0; e_data_a = '0; e_en_a = 1'b0;
            e_addr_b = '0; e_data_b = '0; e_en_b = 1'b0;
        end else begin
            for (int k = 0; k < NU; k++) rdy[k] = m_ready_en && (mq[k].size() < DP);
            ga = -1;
            gb = -1;
            for (int i = 0; i < NU; i++) begin
                u = (m_rr + i) % NU;
                if (mq[u].size() > 0 && mq[u][0][37]) begin
                    if (ga < 0) ga = u;
                    else if (gb < 0 && mq[u][0][36:32] != mq[ga][0][36:32]) gb = u;
                end
            end
            e_en_a = 1'b0;
            e_en_b = 1'b0;
            if (ga >= 0) begin
                e_addr_a = mq[ga][0][36:32];
                e_data_a = mq[ga][0][31:0];
                e_en_a   = (e_addr_a != 5'd0);
            end
            if (gb >= 0) begin
                e_addr_b = mq[gb][0][36:32];
                e_data_b = mq[gb][0][31:0];
                e_en_b   = (e_addr_b != 5'd0);
            end
            if (gb >= 0)      m_rr = (gb + 1) % NU;
            else if (ga >= 0) m_rr = (ga + 1) % NU;
            for (int k = 0; k < NU; k++)
                if (mq[k].size() > 0 && (!mq[k][0][37] || k == ga || k == gb))
                    void'(mq[k].pop_front());
            for (int k = 0; k < NU; k++)
                if (bus.fu_wb_valid[k] && rdy[k])
                    mq[k].push_back({bus.fu_wb_writereg[k], bus.fu_wb_regdest[5*k +: 5],
                                     bus.fu_wb_data[32*k +: 32]});
            m_ready_en = 1'b1;
        end
    end

    always @(negedge clock) begin
        logic [NU-1:0] exp_ready;
        logic          exp_busy;
        if (started) begin
            exp_busy = 1'b0;
            for (int k = 0; k < NU; k++) begin
                exp_ready[k] = m_ready_en && (mq[k].size() < DP);
                if (mq[k].size() > 0) exp_busy = 1'b1;
            end
            chk("m_ready",  32'(bus.fu_wb_ready), 32'(exp_ready));
            chk("m_busy",   32'(bus.wb_busy), 32'(exp_busy));
            chk("m_en_a",   32'(bus.wb_reg_enablewrite_a), 32'(e_en_a));
            chk("m_addr_a", 32'(bus.wb_reg_writeaddr_a), 32'(e_addr_a));
            chk("m_data_a", bus.wb_reg_writedata_a, e_data_a);
            chk("m_en_b",   32'(bus.wb_reg_enablewrite_b), 32'(e_en_b));
            chk("m_addr_b", 32'(bus.wb_reg_writeaddr_b), 32'(e_addr_b));
            chk("m_data_b", bus.wb_reg_writedata_b, e_data_b);
            if (bus.wb_reg_enablewrite_a) wlog.push_back(bus.wb_reg_writedata_a);
            if (bus.wb_reg_enablewrite_b) wlog.push_back(bus.wb_reg_writedata_b);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(input int u, input logic wr, input logic [4:0] d, input logic [31:0] data);
        bus.fu_wb_valid[u]         = 1'b1;
        bus.fu_wb_writereg[u]      = wr;
        bus.fu_wb_regdest[5*u +: 5] = d;
        bus.fu_wb_data[32*u +: 32] = data;
    endtask

    task automatic drop(input int u);
        bus.fu_wb_valid[u] = 1'b0;
    endtask

    task automatic chk_a(input string name, input logic [4:0] addr, input logic [31:0] data, input logic en);
        chk({name, "_addr_a"}, 32'(bus.wb_reg_writeaddr_a), 32'(addr));
        chk({name, "_data_a"}, bus.wb_reg_writedata_a, data);
        chk({name, "_en_a"},   32'(bus.wb_reg_enablewrite_a), 32'(en));
    endtask

    task automatic chk_b(input string name, input logic [4:0] addr, input logic [31:0] data, input logic en);
        chk({name, "_addr_b"}, 32'(bus.wb_reg_writeaddr_b), 32'(addr));
        chk({name, "_data_b"}, bus.wb_reg_writedata_b, data);
        chk({name, "_en_b"},   32'(bus.wb_reg_enablewrite_b), 32'(en));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] u0_log [$];
        bus.fu_wb_valid    = '0;
        bus.fu_wb_writereg = '0;
        bus.fu_wb_regdest  = '0;
        bus.fu_wb_data     = '0;
        reset = 1'b1;
        #1 reset = 1'b0;
        started = 1'b1;

        // Reset with valids driven
        for (int u = 0; u < NU; u++) put(u, 1'b1, 5'(u + 1), 32'hAAAA_0000 + u);
        repeat (3) tick();
        chk("rst_ready", 32'(bus.fu_wb_ready), 32'h0);
        chk("rst_busy",  32'(bus.wb_busy), 32'h0);
        chk_a("rst", 5'd0, 32'h0, 1'b0);
        chk_b("rst", 5'd0, 32'h0, 1'b0);
        for (int u = 0; u < NU; u++) drop(u);
        reset = 1'b1;
        #1 chk("rel_ready0", 32'(bus.fu_wb_ready), 32'h0);
        tick();
        chk("rel_ready", 32'(bus.fu_wb_ready), 32'hF);
        chk("rel_busy",  32'(bus.wb_busy), 32'h0);
        chk("rel_en_a",  32'(bus.wb_reg_enablewrite_a), 32'h0);

        // Round robin from rr_ptr=0
        for (int u = 0; u < NU; u++) put(u, 1'b1, 5'(u + 1), 32'h1000_0000 + u);
        tick();
        for (int u = 0; u < NU; u++) drop(u);
        chk("rr0_busy", 32'(bus.wb_busy), 32'h1);
        chk("rr0_en0",  32'(bus.wb_reg_enablewrite_a), 32'h0);
        tick();
        chk_a("rr0_c1", 5'd1, 32'h1000_0000, 1'b1);
        chk_b("rr0_c1", 5'd2, 32'h1000_0001, 1'b1);
        tick();
        chk_a("rr0_c2", 5'd3, 32'h1000_0002, 1'b1);
        chk_b("rr0_c2", 5'd4, 32'h1000_0003, 1'b1);
        tick();
        chk("rr0_idle_a", 32'(bus.wb_reg_enablewrite_a), 32'h0);
        chk("rr0_idle_b", 32'(bus.wb_reg_enablewrite_b), 32'h0);

        // Single result, two-edge latency; leaves rr_ptr=3
        put(2, 1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        drop(2);
        chk("single_e0", 32'(bus.wb_reg_enablewrite_a), 32'h0);
        tick();
        chk_a("single", 5'd5, 32'hDEAD_BEEF, 1'b1);
        chk("single_en_b", 32'(bus.wb_reg_enablewrite_b), 32'h0);
        tick();
        chk_a("single_hold", 5'd5, 32'hDEAD_BEEF, 1'b0);

        // Round robin from rr_ptr=3
        for (int u = 0; u < NU; u++) put(u, 1'b1, 5'(u + 1), 32'h2000_0000 + u);
        tick();
        for (int u = 0; u < NU; u++) drop(u);
        tick();
        chk_a("rr3_c1", 5'd4, 32'h2000_0003, 1'b1);
        chk_b("rr3_c1", 5'd1, 32'h2000_0000, 1'b1);
        tick();
        chk_a("rr3_c2", 5'd2, 32'h2000_0001, 1'b1);
        chk_b("rr3_c2", 5'd3, 32'h2000_0002, 1'b1);
        tick();

        // Same destination: second head waits
        put(0, 1'b1, 5'd7, 32'h7000_0000);
        put(1, 1'b1, 5'd7, 32'h7000_0001);
        tick();
        drop(0); drop(1);
        tick();
        chk_a("same_c1", 5'd7, 32'h7000_0000, 1'b1);
        chk("same_c1_en_b", 32'(bus.wb_reg_enablewrite_b), 32'h0);
        tick();
        chk_a("same_c2", 5'd7, 32'h7000_0001, 1'b1);
        chk("same_c2_en_b", 32'(bus.wb_reg_enablewrite_b), 32'h0);
        tick();

        // Backpressure on unit 0, all units aimed at r9 (rr_ptr=2)
        wlog.delete();
        put(0, 1'b1, 5'd9, 32'h5000_0000);
        for (int u = 1; u < NU; u++) put(u, 1'b1, 5'd9, 32'h6000_0000 + u);
        tick();
        for (int u = 1; u < NU; u++) drop(u);
        put(0, 1'b1, 5'd9, 32'h5000_0001);
        chk("bp_ready_e0", 32'(bus.fu_wb_ready[0]), 32'h1);
        tick();
        put(0, 1'b1, 5'd9, 32'h5000_0002);
        chk("bp_full_e1", 32'(bus.fu_wb_ready[0]), 32'h0);
        chk_a("bp_e1", 5'd9, 32'h6000_0002, 1'b1);
        tick();
        chk("bp_full_e2", 32'(bus.fu_wb_ready[0]), 32'h0);
        tick();
        chk("bp_ready_e3", 32'(bus.fu_wb_ready[0]), 32'h1);
        tick();
        drop(0);
        repeat (4) tick();
        foreach (wlog[i]) if (wlog[i][31:28] == 4'h5) u0_log.push_back(wlog[i]);
        chk("bp_count", 32'(u0_log.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("bp_order", (i < u0_log.size()) ? u0_log[i] : 32'hFFFF_FFFF, 32'h5000_0000 + i);

        // Free drain of writereg=0 entry
        put(1, 1'b0, 5'd12, 32'hC000_0001);
        tick();
        drop(1);
        chk("drain_busy", 32'(bus.wb_busy), 32'h1);
        tick();
        chk_a("drain", 5'd9, 32'h5000_0002, 1'b0);
        chk("drain_en_b", 32'(bus.wb_reg_enablewrite_b), 32'h0);
        chk("drain_idle", 32'(bus.wb_busy), 32'h0);

        // r0 target consumes port B without a strobe (rr_ptr=1)
        put(3, 1'b1, 5'd0,  32'hD000_0003);
        put(0, 1'b1, 5'd10, 32'hD000_0000);
        put(1, 1'b1, 5'd11, 32'hD000_0001);
        tick();
        drop(0); drop(1); drop(3);
        tick();
        chk_a("r0_c1", 5'd11, 32'hD000_0001, 1'b1);
        chk_b("r0_c1", 5'd0,  32'hD000_0003, 1'b0);
        tick();
        chk_a("r0_c2", 5'd10, 32'hD000_0000, 1'b1);
        chk("r0_c2_en_b", 32'(bus.wb_reg_enablewrite_b), 32'h0);
        tick();

        // Reset while four results are buffered
        for (int u = 0; u < NU; u++) put(u, 1'b1, 5'(20 + u), 32'hE000_0000 + u);
        tick();
        for (int u = 0; u < NU; u++) drop(u);
        chk("mid_busy", 32'(bus.wb_busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy",  32'(bus.wb_busy), 32'h0);
        chk("mid_rst_ready", 32'(bus.fu_wb_ready), 32'h0);
        chk_a("mid_rst", 5'd0, 32'h0, 1'b0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("mid_rel_ready", 32'(bus.fu_wb_ready), 32'hF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_wr_a", 32'(bus.wb_reg_enablewrite_a), 32'h0);
            chk("mid_no_wr_b", 32'(bus.wb_reg_enablewrite_b), 32'h0);
            chk("mid_no_busy", 32'(bus.wb_busy), 32'h0);
        end

        started = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
